// File: rtl/reg_bank.sv
// reg_bank: memory-mapped bank of RW, RO and W1C registers behind a
// valid/ready request/response handshake with one-cycle registered response.
module reg_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  input  logic [DATA_W/8-1:0]        req_wstrb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  input  logic [NUM_REGS*DATA_W-1:0] hw_in,
  output logic [NUM_REGS*DATA_W-1:0] reg_out
);
  localparam int IW = ADDR_W - 2;
  localparam int NB = DATA_W / 8;
  typedef enum logic {IDLE, RESP} state_t;
  state_t state_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rdata_q, rdata_d, wmask, rd_val;
  logic err_q, err_d, acc, dec_err, wr, sel_ro;
  logic [IW-1:0] idx;
  assign idx = req_addr[ADDR_W-1:2];
  assign acc = state_q == IDLE && req_valid;
  assign dec_err = |req_addr[1:0] || 32'(idx) >= NUM_REGS;
  assign wr = acc && req_write && !dec_err && |req_wstrb;
  // W1C: hardware sets are OR-ed in after the software clear so a set wins
  always_comb begin
    wmask = '0;
    rd_val = '0;
    sel_ro = 1'b0;
    for (int b = 0; b < NB; b++) wmask[b*8 +: 8] = {8{req_wstrb[b]}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IW'(i)) begin
        rd_val = RO_MASK[i] ? hw_in[i*DATA_W +: DATA_W] : regs_q[i];
        sel_ro = RO_MASK[i];
      end
      regs_d[i] = RO_MASK[i] ? '0
        : W1C_MASK[i] ? (regs_q[i] & ~((wr && idx == IW'(i)) ? req_wdata & wmask : '0)) | hw_in[i*DATA_W +: DATA_W]
        : (wr && idx == IW'(i)) ? (regs_q[i] & ~wmask) | (req_wdata & wmask) : regs_q[i];
    end
    err_d = dec_err || (req_write && |req_wstrb && sel_ro);
    rdata_d = (dec_err || req_write) ? '0 : rd_val;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q <= 1'b0;
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
      if (acc) begin
        state_q <= RESP;
        rdata_q <= rdata_d;
        err_q <= err_d;
      end else if (state_q == RESP && rsp_ready) begin
        state_q <= IDLE;
      end
    end
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = regs_q[g];
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 10: byte-address width.
REQ-003 Parameter NUM_REGS, default 8: register count; register i at byte address 4*i.
REQ-004 Parameter RO_MASK, default 0: bit i=1 makes register i read-only, value taken from hw_in.
REQ-005 Parameter W1C_MASK, default 0: bit i=1 makes register i a write-1-to-clear status register; RO_MASK takes precedence.
REQ-006 The block SHALL use one clock, clk, and a synchronous active-high reset, rst.
REQ-007 clk  input  1  clock; all state updates on its rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 req_valid  input  1  request present.
REQ-010 req_ready  output  1  block can accept a request.
REQ-011 req_write  input  1  1=write, 0=read.
REQ-012 req_addr  input  ADDR_W  byte address.
REQ-013 req_wdata  input  DATA_W  write data.
REQ-014 req_wstrb  input  DATA_W/8  byte-lane write enables.
REQ-015 rsp_valid  output  1  response present.
REQ-016 rsp_ready  input  1  response consumed.
REQ-017 rsp_rdata  output  DATA_W  read data.
REQ-018 rsp_err  output  1  access error flag.
REQ-019 hw_in  input  NUM_REGS*DATA_W  RO register values or W1C set pulses, slice i for register i.
REQ-020 reg_out  output  NUM_REGS*DATA_W  current stored value of every register, slice i for register i.

Function
REQ-021 FSM states SHALL be IDLE and RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-022 Acceptance SHALL occur on an edge with req_valid=1 in IDLE; the FSM moves to RESP on that edge.
REQ-023 The FSM SHALL return from RESP to IDLE on an edge with rsp_ready=1; rsp_rdata and rsp_err SHALL hold stable while rsp_valid=1.
REQ-024 Latency: rsp_valid SHALL rise exactly one cycle after acceptance; there is no combinational path from req_* to rsp_*.
REQ-025 Decode error: req_addr[1:0]!=0 or req_addr[ADDR_W-1:2]>=NUM_REGS SHALL give rsp_err=1 and rsp_rdata=0, with no state change.
REQ-026 Write to an RO register SHALL give rsp_err=1 and SHALL NOT change state.
REQ-027 Write to an RW register SHALL update only the byte lanes whose req_wstrb bit is 1, on the acceptance edge.
REQ-028 Write to a W1C register SHALL clear each stored bit whose req_wdata bit is 1 and whose lane strobe is 1; other bits are unchanged.
REQ-029 Each W1C register bit SHALL be set every cycle its hw_in bit is 1; a set SHALL win over a clear in the same cycle.
REQ-030 A write with req_wstrb=0 SHALL change nothing and give rsp_err=0.
REQ-031 Read of an RW or W1C register SHALL return the stored value at the acceptance edge; read of an RO register SHALL return hw_in slice i sampled at the acceptance edge.
REQ-032 A successful write SHALL return rsp_rdata=0 and rsp_err=0.
REQ-033 reg_out for an RO register SHALL be 0; the RO value appears only in read data.
REQ-034 Requests presented while in RESP SHALL be ignored (req_ready=0).

Reset
REQ-035 While rst=1 on an edge: all registers=0, state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-036 rst SHALL take precedence over hw_in sets, writes and handshakes; a response pending in RESP SHALL be discarded.
REQ-037 After reset, req_ready SHALL be 1 in the first cycle with rst=0.

Verification
REQ-038 Reset, then write 0xF0F0F0F0 to addr 0x0 with wstrb=0xF, then read 0x0 -> write response err=0, rdata=0; read response 0xF0F0F0F0, reg_out[0]=0xF0F0F0F0.
REQ-039 Write 0x55555555 to 0x0 with wstrb=0x3, then read 0x0 -> read returns 0xF0F05555.
REQ-040 Read addr 0x2 and addr 0x20 (NUM_REGS=8) -> both err=1, rdata=0, no register changes.
REQ-041 RO_MASK=0x02, hw_in[1]=0x12345678: read 0x4 returns 0x12345678, err=0; write 0x4 gives err=1 and reg_out[1] stays 0.
REQ-042 W1C_MASK=0x04: pulse hw_in[2] bit0 and bit4 -> reg 0x8 reads 0x11. Write 0x01 (wstrb=0xF) -> reads 0x10. Write 0x10 in the same cycle as an hw_in bit4 pulse -> still reads 0x10.
REQ-043 Hold rsp_ready=0 for 3 cycles after a read -> rsp_valid stays 1, data stable, req_ready=0. Assert rst mid-RESP -> rsp_valid=0 next cycle and all registers read 0.
